imm_gen: RTL and testbench

- RV32I immediate generator in the ID stage; decodes the 32-bit instruction word into a sign-extended immediate (Imm_id) and a control-transfer byte offset (offset).
- Both are combinational from inst.
- Also holds an ID/EX pipeline register (Imm_ex, offset_ex) with stall/flush, feeding the EX-stage ALU and branch-target adder.

---
 rtl/imm_gen.sv | 126 ++++++++++++
 tb/tb_imm_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen.sv
// RV32I immediate generator (ID stage) with the ID/EX immediate/offset register.
// Optional macro IMMGEN_ILLEGAL_EN adds illegal_id / illegal_ex opcode flags.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            stall,
  input  logic            flush,
`ifdef IMMGEN_ILLEGAL_EN
  output logic            illegal_id,
  output logic            illegal_ex,
`endif
  output logic [XLEN-1:0] Imm_id,
  output logic [XLEN-1:0] offset,
  output logic [XLEN-1:0] Imm_ex,
  output logic [XLEN-1:0] offset_ex
);

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] off_s;
  logic            illegal_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];

  // Format decode: immediate, control-transfer offset and legality of the opcode.
  always_comb begin
    imm_s     = 32'd0;
    off_s     = 32'd0;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_LOAD, OP_MISC_MEM, OP_SYSTEM: begin
        imm_s = {{20{inst[31]}}, inst[31:20]};
      end
      OP_OP_IMM: begin
        // Shift amounts are unsigned; the upper funct7 bits are not part of the value.
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          imm_s = {27'd0, inst[24:20]};
        end else begin
          imm_s = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OP_JALR: begin
        imm_s = {{20{inst[31]}}, inst[31:20]};
        off_s = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        off_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_JAL: begin
        imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        off_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_s = {inst[31:12], 12'd0};
      end
      OP_OP: begin
        imm_s = 32'd0;
      end
      default: begin
        // Covers every non-RV32I opcode, including all with inst[1:0] != 2'b11.
        illegal_s = 1'b1;
      end
    endcase
  end

  assign Imm_id = imm_s;
  assign offset = off_s;

  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] off_r;
  logic            illegal_r;

  // ID/EX register: reset and flush clear, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_r     <= 32'd0;
      off_r     <= 32'd0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      imm_r     <= 32'd0;
      off_r     <= 32'd0;
      illegal_r <= 1'b0;
    end else if (!stall) begin
      imm_r     <= imm_s;
      off_r     <= off_s;
      illegal_r <= illegal_s;
    end else begin
      imm_r     <= imm_r;
      off_r     <= off_r;
      illegal_r <= illegal_r;
    end
  end

  assign Imm_ex    = imm_r;
  assign offset_ex = off_r;

`ifdef IMMGEN_ILLEGAL_EN
  assign illegal_id = illegal_s;
  assign illegal_ex = illegal_r;
`else
  logic unused_s;
  assign unused_s = illegal_s ^ illegal_r;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen: decode vectors, ID/EX stall/flush and async reset.
module tb_imm_gen;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        stall;
  logic        flush;
  logic [31:0] Imm_id;
  logic [31:0] offset;
  logic [31:0] Imm_ex;
  logic [31:0] offset_ex;
`ifdef IMMGEN_ILLEGAL_EN
  logic        illegal_id;
  logic        illegal_ex;
`endif

  int checks = 0;
  int errors = 0;

  imm_gen #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .stall     (stall),
    .flush     (flush),
`ifdef IMMGEN_ILLEGAL_EN
    .illegal_id(illegal_id),
    .illegal_ex(illegal_ex),
`endif
    .Imm_id    (Imm_id),
    .offset    (offset),
    .Imm_ex    (Imm_ex),
    .offset_ex (offset_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [31:0] i, input logic [31:0] ei, input logic [31:0] eo);
    inst = i;
    #1;
    chk({tag, "_imm"}, Imm_id, ei);
    chk({tag, "_off"}, offset, eo);
  endtask

  initial begin
    rst   = 1'b1;
    inst  = 32'h0000_0000;
    stall = 1'b0;
    flush = 1'b0;
    #12;
    chk("reset_imm_ex", Imm_ex, 32'h0000_0000);
    chk("reset_off_ex", offset_ex, 32'h0000_0000);

    // Combinational decode vectors
    dec("load",     32'h3e81_3083, 32'h0000_03e8, 32'h0000_0000);
    dec("store",    32'h3e11_3423, 32'h0000_03e8, 32'h0000_0000);
    dec("jal",      32'h7d00_006f, 32'h0000_07d0, 32'h0000_07d0);
    dec("branch",   32'h7cb5_1863, 32'h0000_07d0, 32'h0000_07d0);
    dec("addi_m1",  32'hfff0_0513, 32'hffff_ffff, 32'h0000_0000);
    dec("beq_m4",   32'hfe00_0ee3, 32'hffff_fffc, 32'hffff_fffc);
    dec("lui",      32'h1234_5037, 32'h1234_5000, 32'h0000_0000);
    dec("auipc",    32'hffff_f097, 32'hffff_f000, 32'h0000_0000);
    dec("jalr_m8",  32'hff80_8067, 32'hffff_fff8, 32'hffff_fff8);
    dec("srai31",   32'h41f0_d093, 32'h0000_001f, 32'h0000_0000);
    dec("jal_min",  32'h8000_006f, 32'hfff0_0000, 32'hfff0_0000);
    dec("r_add",    32'h0020_81b3, 32'h0000_0000, 32'h0000_0000);
    dec("bad_op",   32'hfff0_007f, 32'h0000_0000, 32'h0000_0000);
    dec("bad_lsb",  32'hfff0_0510, 32'h0000_0000, 32'h0000_0000);
`ifdef IMMGEN_ILLEGAL_EN
    chk("illegal_lsb", {31'd0, illegal_id}, 32'h0000_0001);
    inst = 32'h3e81_3083;
    #1;
    chk("legal_load", {31'd0, illegal_id}, 32'h0000_0000);
`endif

    // Release reset, load an immediate
    @(negedge clk);
    rst  = 1'b0;
    inst = 32'h3e81_3083;
    @(posedge clk); #1;
    chk("load_imm_ex", Imm_ex, 32'h0000_03e8);
    chk("load_off_ex", offset_ex, 32'h0000_0000);

    // Branch: offset register captures too
    @(negedge clk);
    inst = 32'h7cb5_1863;
    @(posedge clk); #1;
    chk("br_imm_ex", Imm_ex, 32'h0000_07d0);
    chk("br_off_ex", offset_ex, 32'h0000_07d0);

    // Stall holds while inst changes; comb outputs still follow inst
    @(negedge clk);
    stall = 1'b1;
    inst  = 32'h1234_5037;
    @(posedge clk); #1;
    chk("stall_imm_ex", Imm_ex, 32'h0000_07d0);
    chk("stall_off_ex", offset_ex, 32'h0000_07d0);
    chk("stall_comb", Imm_id, 32'h1234_5000);
    @(posedge clk); #1;
    chk("stall2_imm_ex", Imm_ex, 32'h0000_07d0);

    // Flush beats stall
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_stall_imm_ex", Imm_ex, 32'h0000_0000);
    chk("flush_stall_off_ex", offset_ex, 32'h0000_0000);
    chk("flush_comb", Imm_id, 32'h1234_5000);

    // Reload after stall/flush drop
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    inst  = 32'hfe00_0ee3;
    @(posedge clk); #1;
    chk("beq_imm_ex", Imm_ex, 32'hffff_fffc);
    chk("beq_off_ex", offset_ex, 32'hffff_fffc);

    // Flush alone
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_imm_ex", Imm_ex, 32'h0000_0000);
    @(negedge clk);
    flush = 1'b0;
    inst  = 32'h7d00_006f;
    @(posedge clk); #1;
    chk("jal_imm_ex", Imm_ex, 32'h0000_07d0);
    chk("jal_off_ex", offset_ex, 32'h0000_07d0);

    // Async reset between edges, mid-stall
    #1;
    stall = 1'b1;
    rst   = 1'b1;
    #1;
    chk("async_imm_ex", Imm_ex, 32'h0000_0000);
    chk("async_off_ex", offset_ex, 32'h0000_0000);
    chk("rst_comb", offset, 32'h0000_07d0);

    // Release takes effect at next edge
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    inst  = 32'hfff0_0513;
    @(posedge clk); #1;
    chk("post_rst_imm_ex", Imm_ex, 32'hffff_ffff);
    chk("post_rst_off_ex", offset_ex, 32'h0000_0000);
`ifdef IMMGEN_ILLEGAL_EN
    chk("ill_ex_legal", {31'd0, illegal_ex}, 32'h0000_0000);
    @(negedge clk);
    inst = 32'h0000_007f;
    @(posedge clk); #1;
    chk("ill_ex_set", {31'd0, illegal_ex}, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
